imm_packer: RTL

- Inverse of the decode-side immediate generator: packs a 32-bit immediate into the immediate field(s) of a LoongArch instruction template.
- Selects the field layout by immediate type and range-checks the value against that field.
- Feeds the debug/instruction-injection path, which patches branch offsets and constants into pre-built instruction words before issue.
- 2-stage valid/ready pipeline with a saturating range-error counter.

---
 rtl/cpuDefine.sv | 56 +++++
 rtl/imm_field_enc.sv | 63 ++++++
 rtl/imm_packer.sv | 94 +++++++++
 3 files changed

// File: rtl/cpuDefine.sv
// Shared CPU types and immediate-field geometry used by both the decode-side
// immediate generator and the injection-path immediate packer.
package cpuDefine;

   typedef logic [31:0] Instr;
   typedef logic [31:0] DType;

   typedef enum logic [2:0] {
      IT_I8  = 3'd0,
      IT_I12 = 3'd1,
      IT_I14 = 3'd2,
      IT_I16 = 3'd3,
      IT_I20 = 3'd4,
      IT_I21 = 3'd5,
      IT_I26 = 3'd6
   } Itype;

   localparam int unsigned I8_LSB     = 10;
   localparam int unsigned I8_MSB     = 14;
   localparam int unsigned I12_LSB    = 10;
   localparam int unsigned I12_MSB    = 21;
   localparam int unsigned I14_LSB    = 10;
   localparam int unsigned I14_MSB    = 23;
   localparam int unsigned I16_LSB    = 10;
   localparam int unsigned I16_MSB    = 25;
   localparam int unsigned I20_LSB    = 5;
   localparam int unsigned I20_MSB    = 24;
   localparam int unsigned I21_LO_LSB = 0;
   localparam int unsigned I21_LO_MSB = 4;
   localparam int unsigned I26_LO_LSB = 0;
   localparam int unsigned I26_LO_MSB = 9;

   // Stage-1 payload: template plus the pre-computed field overlay.
   typedef struct packed {
      Instr tmpl;
      Instr mask;
      Instr bits;
      logic err;
   } s1_t;

   function automatic Instr field_mask(input int unsigned lsb, input int unsigned msb);
      return (32'hFFFF_FFFF >> (31 - msb)) & (32'hFFFF_FFFF << lsb);
   endfunction

   // True when every bit from 'top' upward equals the sign bit.
   function automatic logic fits_signed(input DType v, input int unsigned top);
      logic signed [31:0] s;
      s = $signed(v) >>> top;
      return (s == 32'sd0) || (s == -32'sd1);
   endfunction

   function automatic logic fits_unsigned(input DType v, input int unsigned top);
      return (v >> (top + 1)) == 32'd0;
   endfunction

endpackage

// File: rtl/imm_field_enc.sv
// Combinational map from immediate type/value to field mask, packed bits and range error.
// Zero latency; no flow control (pure function of its inputs).
module imm_field_enc
   import cpuDefine::*;
(
   input  Itype itype_i,
   input  logic unsign_i,
   input  DType imm_i,
   output Instr mask_o,
   output Instr bits_o,
   output logic err_o
);

   always_comb begin
      mask_o = '0;
      bits_o = '0;
      err_o  = 1'b1;
      case (itype_i)
         IT_I8: begin
            mask_o = field_mask(I8_LSB, I8_MSB);
            bits_o = DType'(imm_i[4:0]) << I8_LSB;
            err_o  = !fits_unsigned(imm_i, 4);
         end
         IT_I12: begin
            mask_o = field_mask(I12_LSB, I12_MSB);
            bits_o = DType'(imm_i[11:0]) << I12_LSB;
            err_o  = unsign_i ? !fits_unsigned(imm_i, 11) : !fits_signed(imm_i, 11);
         end
         IT_I14: begin
            mask_o = field_mask(I14_LSB, I14_MSB);
            bits_o = DType'(imm_i[15:2]) << I14_LSB;
            err_o  = !fits_signed(imm_i, 15) || (imm_i[1:0] != 2'b00);
         end
         IT_I16: begin
            mask_o = field_mask(I16_LSB, I16_MSB);
            bits_o = DType'(imm_i[17:2]) << I16_LSB;
            err_o  = !fits_signed(imm_i, 17) || (imm_i[1:0] != 2'b00);
         end
         IT_I20: begin
            mask_o = field_mask(I20_LSB, I20_MSB);
            bits_o = DType'(imm_i[31:12]) << I20_LSB;
            err_o  = (imm_i[11:0] != 12'd0);
         end
         IT_I21: begin
            // Split offset: low 16 bits share the I16 slot, high 5 bits sit at the bottom.
            mask_o = field_mask(I16_LSB, I16_MSB) | field_mask(I21_LO_LSB, I21_LO_MSB);
            bits_o = (DType'(imm_i[15:0]) << I16_LSB) | (DType'(imm_i[20:16]) << I21_LO_LSB);
            err_o  = !fits_signed(imm_i, 20);
         end
         IT_I26: begin
            mask_o = field_mask(I16_LSB, I16_MSB) | field_mask(I26_LO_LSB, I26_LO_MSB);
            bits_o = (DType'(imm_i[17:2]) << I16_LSB) | (DType'(imm_i[27:18]) << I26_LO_LSB);
            err_o  = !fits_signed(imm_i, 27) || (imm_i[1:0] != 2'b00);
         end
         default: begin
            mask_o = '0;
            bits_o = '0;
            err_o  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_packer.sv
// Packs an immediate into a LoongArch instruction template; 2-cycle latency, 1/cycle throughput.
// Valid/ready on both sides; in_ready follows out_ready combinationally, held output stays stable.
module imm_packer
   import cpuDefine::*;
#(
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  Instr                 in_tmpl,
   input  Itype                 in_itype,
   input  logic                 in_unsign,
   input  DType                 in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output Instr                 out_instr,
   output logic                 out_err,
   input  logic                 flush,
   output logic [ERR_CNT_W-1:0] err_cnt,
   input  logic                 err_cnt_clr
);

   localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

   s1_t                  s1_q, s1_d;
   logic                 s1_vld_q, s1_vld_d;
   logic                 s2_vld_q, s2_vld_d;
   Instr                 s2_instr_q, s2_instr_d;
   logic                 s2_err_q, s2_err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   Instr enc_mask, enc_bits;
   logic enc_err;
   logic s2_load, accept;

   imm_field_enc u_enc (
      .itype_i  (in_itype),
      .unsign_i (in_unsign),
      .imm_i    (in_imm),
      .mask_o   (enc_mask),
      .bits_o   (enc_bits),
      .err_o    (enc_err)
   );

   always_comb begin
      s2_load  = !s2_vld_q || out_ready;
      in_ready = !flush && (!s1_vld_q || s2_load);
      accept   = in_valid && in_ready;

      s1_vld_d = flush ? 1'b0 : (in_ready ? in_valid : s1_vld_q);
      s1_d     = accept ? '{tmpl: in_tmpl, mask: enc_mask, bits: enc_bits, err: enc_err} : s1_q;

      s2_vld_d   = flush ? 1'b0 : (s2_load ? s1_vld_q : s2_vld_q);
      s2_instr_d = s2_instr_q;
      s2_err_d   = s2_err_q;
      if (s2_load && s1_vld_q) begin
         s2_instr_d = (s1_q.tmpl & ~s1_q.mask) | s1_q.bits;
         s2_err_d   = s1_q.err;
      end

      // Clear wins over a same-cycle increment.
      err_cnt_d = err_cnt_q;
      if (err_cnt_clr)
         err_cnt_d = '0;
      else if (s2_vld_q && out_ready && s2_err_q && (err_cnt_q != '1))
         err_cnt_d = err_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= '0;
         s1_vld_q   <= 1'b0;
         s2_vld_q   <= 1'b0;
         s2_instr_q <= '0;
         s2_err_q   <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         s1_q       <= s1_d;
         s1_vld_q   <= s1_vld_d;
         s2_vld_q   <= s2_vld_d;
         s2_instr_q <= s2_instr_d;
         s2_err_q   <= s2_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign out_valid = s2_vld_q;
   assign out_instr = s2_instr_q;
   assign out_err   = s2_err_q;
   assign err_cnt   = err_cnt_q;

endmodule
